// File: rtl/sensor_hcsr04_emulador_pkg.sv
// Shared constants for the HC-SR04 emulator and the sensor interface that talks to it:
// state encoding and default protocol timing at 50 MHz.
package sensor_hcsr04_emulador_pkg;

   typedef logic [2:0] estado_t;

   localparam estado_t ST_IDLE    = 3'd0;
   localparam estado_t ST_TRIG    = 3'd1;
   localparam estado_t ST_BURST   = 3'd2;
   localparam estado_t ST_ECHO    = 3'd3;
   localparam estado_t ST_HOLDOFF = 3'd4;

   localparam int TRIG_MIN_DEF    = 500;
   localparam int CM_CLOCKS_DEF   = 2941;
   localparam int BURST_DELAY_DEF = 25000;
   localparam int DIST_MAX_DEF    = 400;
   localparam int TIMEOUT_DEF     = 1900000;
   localparam int REARM_DEF       = 500000;

endpackage

// File: rtl/sensor_hcsr04_emulador_gerador_eco_cm.sv
// Echo width generator: nested clocks-per-cm and cm counters, or a single TIMEOUT-long
// run of the inner counter when the latched distance is out of range.
module gerador_eco_cm
   import sensor_hcsr04_emulador_pkg::*;
#(
   parameter int CM_CLOCKS = CM_CLOCKS_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] cm,
   input  logic       timeout_sel,
   output logic       echo,
   output logic       fim
);

   localparam int CNT_W = $clog2(((TIMEOUT > CM_CLOCKS) ? TIMEOUT : CM_CLOCKS) + 1);
   localparam logic [CNT_W-1:0] CM_LAST = CNT_W'(CM_CLOCKS - 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic             ativo_r;
   logic [CNT_W-1:0] clk_cnt_r;
   logic [9:0]       cm_cnt_r;

   assign echo = ativo_r;
   assign fim  = ativo_r && (clk_cnt_r == {CNT_W{1'b0}}) && (cm_cnt_r == 10'd0);

   // Pulse counters: inner counter reloads once per cm until the cm counter is exhausted
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ativo_r   <= 1'b0;
         clk_cnt_r <= {CNT_W{1'b0}};
         cm_cnt_r  <= 10'd0;
      end else if (start) begin
         ativo_r   <= 1'b1;
         clk_cnt_r <= timeout_sel ? TO_LAST : CM_LAST;
         cm_cnt_r  <= timeout_sel ? 10'd0 : (cm - 10'd1);
      end else if (ativo_r) begin
         if (clk_cnt_r == {CNT_W{1'b0}}) begin
            if (cm_cnt_r == 10'd0) begin
               ativo_r <= 1'b0;
            end else begin
               cm_cnt_r  <= cm_cnt_r - 10'd1;
               clk_cnt_r <= CM_LAST;
            end
         end else begin
            clk_cnt_r <= clk_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/sensor_hcsr04_emulador.sv
// HC-SR04 sensor-side emulator: validates the trigger, waits the burst delay, then
// returns an echo whose width encodes the programmed BCD distance.
module sensor_hcsr04_emulador
   import sensor_hcsr04_emulador_pkg::*;
#(
   parameter int TRIG_MIN    = TRIG_MIN_DEF,
   parameter int CM_CLOCKS   = CM_CLOCKS_DEF,
   parameter int BURST_DELAY = BURST_DELAY_DEF,
   parameter int DIST_MAX    = DIST_MAX_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int REARM       = REARM_DEF
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        trigger,
   input  logic [11:0] distancia,
   input  logic        habilita,
   output logic        echo,
   output logic        ocupado,
   output logic        pronto,
   output logic        trigger_curto,
   output logic [2:0]  db_estado
);

   localparam int TW = $clog2(TRIG_MIN + 1);
   localparam int EW = $clog2(((BURST_DELAY > REARM) ? BURST_DELAY : REARM) + 1);
   localparam logic [TW-1:0] TRIG_MIN_V = TW'(TRIG_MIN);
   localparam logic [EW-1:0] BURST_LAST = EW'(BURST_DELAY - 2);
   localparam logic [EW-1:0] REARM_LAST = EW'(REARM - 1);
   localparam logic [9:0]    DIST_MAX_V = 10'(DIST_MAX);

   logic          trig_meta_r, trig_s_r, trig_prev_r;
   logic          rise_s, fall_s;
   estado_t       state_r, next_s;
   logic [TW-1:0] largura_r;
   logic [EW-1:0] espera_r;
   logic [9:0]    cm_r, valor_s;
   logic          timeout_sel_r, invalido_s;
   logic          start_s, curto_s, aceita_s, fim_s, echo_s;
   logic          ocupado_r, pronto_r, curto_r;

   assign rise_s = trig_s_r & ~trig_prev_r;
   assign fall_s = ~trig_s_r & trig_prev_r;

   // BCD distance to binary cm, flagged invalid on bad digit, zero or beyond range
   always_comb begin
      valor_s    = 10'(distancia[11:8]) * 10'd100 + 10'(distancia[7:4]) * 10'd10
                 + 10'(distancia[3:0]);
      invalido_s = (distancia[11:8] > 4'd9) || (distancia[7:4] > 4'd9)
                || (distancia[3:0] > 4'd9) || (valor_s == 10'd0) || (valor_s > DIST_MAX_V);
   end

   // Next-state logic; the fall-detect cycle counts as the first burst clock
   always_comb begin
      next_s   = state_r;
      start_s  = 1'b0;
      curto_s  = 1'b0;
      aceita_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rise_s && habilita) next_s = ST_TRIG;
            else                    next_s = ST_IDLE;
         end
         ST_TRIG: begin
            if (fall_s) begin
               if (largura_r >= TRIG_MIN_V) begin
                  next_s   = ST_BURST;
                  aceita_s = 1'b1;
               end else begin
                  next_s  = ST_IDLE;
                  curto_s = 1'b1;
               end
            end else begin
               next_s = ST_TRIG;
            end
         end
         ST_BURST: begin
            if (espera_r == BURST_LAST) begin
               next_s  = ST_ECHO;
               start_s = 1'b1;
            end else begin
               next_s = ST_BURST;
            end
         end
         ST_ECHO: begin
            if (fim_s || !echo_s) next_s = ST_HOLDOFF;
            else                  next_s = ST_ECHO;
         end
         ST_HOLDOFF: begin
            if (espera_r == REARM_LAST) next_s = ST_IDLE;
            else                        next_s = ST_HOLDOFF;
         end
         default: next_s = ST_IDLE;
      endcase
   end

   // Two-flop trigger synchronizer plus one stage of history for edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trig_meta_r <= 1'b0;
         trig_s_r    <= 1'b0;
         trig_prev_r <= 1'b0;
      end else begin
         trig_meta_r <= trigger;
         trig_s_r    <= trig_meta_r;
         trig_prev_r <= trig_s_r;
      end
   end

   // State register, width/wait counters, latched distance and registered flags
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         largura_r     <= {TW{1'b0}};
         espera_r      <= {EW{1'b0}};
         cm_r          <= 10'd0;
         timeout_sel_r <= 1'b0;
         ocupado_r     <= 1'b0;
         pronto_r      <= 1'b0;
         curto_r       <= 1'b0;
      end else begin
         state_r <= next_s;
         // the rising-edge cycle itself is the first counted trigger clock
         if (state_r == ST_IDLE) begin
            largura_r <= (rise_s && habilita) ? TW'(1) : {TW{1'b0}};
         end else if (state_r == ST_TRIG) begin
            if (trig_s_r && (largura_r < TRIG_MIN_V)) largura_r <= largura_r + TW'(1);
         end else begin
            largura_r <= {TW{1'b0}};
         end
         if ((next_s == state_r) && ((state_r == ST_BURST) || (state_r == ST_HOLDOFF)))
            espera_r <= espera_r + EW'(1);
         else
            espera_r <= {EW{1'b0}};
         if (aceita_s) begin
            cm_r          <= valor_s;
            timeout_sel_r <= invalido_s;
         end
         ocupado_r <= (next_s != ST_IDLE);
         pronto_r  <= (state_r == ST_ECHO) && (next_s == ST_HOLDOFF);
         curto_r   <= curto_s;
      end
   end

   gerador_eco_cm #(
      .CM_CLOCKS (CM_CLOCKS),
      .TIMEOUT   (TIMEOUT)
   ) u_gerador_eco_cm (
      .clock       (clock),
      .reset       (reset),
      .start       (start_s),
      .cm          (cm_r),
      .timeout_sel (timeout_sel_r),
      .echo        (echo_s),
      .fim         (fim_s)
   );

   assign echo          = echo_s;
   assign ocupado       = ocupado_r;
   assign pronto        = pronto_r;
   assign trigger_curto = curto_r;
   assign db_estado     = state_r;

endmodule

// File: tb/tb_sensor_hcsr04_emulador.sv
// Self-checking bench for the HC-SR04 emulator with scaled-down timing; expected
// widths and latencies come from a distance-rule model, observations from a negedge monitor.
module tb_sensor_hcsr04_emulador;

   localparam int TRIG_MIN    = 20;
   localparam int CM_CLOCKS   = 5;
   localparam int BURST_DELAY = 30;
   localparam int DIST_MAX    = 400;
   localparam int TIMEOUT     = 2101;
   localparam int REARM       = 40;
   localparam int SYNC_LAT    = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        trigger = 1'b0;
   logic        habilita = 1'b1;
   logic [11:0] distancia = 12'h000;
   logic        echo, ocupado, pronto, trigger_curto;
   logic [2:0]  db_estado;

   sensor_hcsr04_emulador #(
      .TRIG_MIN    (TRIG_MIN),
      .CM_CLOCKS   (CM_CLOCKS),
      .BURST_DELAY (BURST_DELAY),
      .DIST_MAX    (DIST_MAX),
      .TIMEOUT     (TIMEOUT),
      .REARM       (REARM)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .trigger       (trigger),
      .distancia     (distancia),
      .habilita      (habilita),
      .echo          (echo),
      .ocupado       (ocupado),
      .pronto        (pronto),
      .trigger_curto (trigger_curto),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic chk_eq(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: posedge count plus echo/pronto/ocupado/trigger_curto event history
   int   cyc = 0;
   logic echo_q = 1'b0, ocup_q = 1'b0;
   int   echo_n = 0, rise_cyc = 0, wid = 0, last_wid = 0, fall_cyc = 0;
   int   pronto_n = 0, pronto_cyc = -1, curto_n = 0, curto_cyc = -1;
   int   ocup_rise_n = 0, ocup_fall_cyc = -1;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      echo_q <= echo;
      ocup_q <= ocupado;
      if (echo && !echo_q) begin
         echo_n   <= echo_n + 1;
         rise_cyc <= cyc;
         wid      <= 1;
      end else if (echo) begin
         wid <= wid + 1;
      end
      if (!echo && echo_q) begin
         last_wid <= wid;
         fall_cyc <= cyc;
      end
      if (pronto) begin
         pronto_n   <= pronto_n + 1;
         pronto_cyc <= cyc;
      end
      if (trigger_curto) begin
         curto_n   <= curto_n + 1;
         curto_cyc <= cyc;
      end
      if (ocupado && !ocup_q) ocup_rise_n <= ocup_rise_n + 1;
      if (!ocupado && ocup_q) ocup_fall_cyc <= cyc;
   end

   // Reference: echo width in clocks from the distance rules
   function automatic int exp_width(input logic [11:0] d);
      int h, t, u, v;
      h = int'(d[11:8]);
      t = int'(d[7:4]);
      u = int'(d[3:0]);
      if (h > 9 || t > 9 || u > 9) return TIMEOUT;
      v = 100 * h + 10 * t + u;
      if (v == 0 || v > DIST_MAX) return TIMEOUT;
      return v * CM_CLOCKS;
   endfunction

   function automatic logic [11:0] to_bcd(input int n);
      logic [11:0] r;
      r[11:8] = 4'(n / 100);
      r[7:4]  = 4'((n / 10) % 10);
      r[3:0]  = 4'(n % 10);
      return r;
   endfunction

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic pulse(input int w, output int fd);
      step();
      trigger = 1'b1;
      repeat (w) step();
      trigger = 1'b0;
      fd = cyc;
   endtask

   task automatic wait_echo(input logic lvl, input int budget, input string tag);
      int n;
      n = 0;
      while (echo !== lvl && n < budget) begin
         step();
         n++;
      end
      chk_eq(tag, int'(echo), int'(lvl));
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      while (ocupado !== 1'b0 && n < budget) begin
         step();
         n++;
      end
      chk_eq(tag, int'(ocupado), 0);
   endtask

   // mode: 0 plain, 1 trigger during echo, 2 trigger during holdoff,
   // 3 distancia changed mid-echo, 4 trigger held past holdoff, 5 habilita dropped in burst
   task automatic meas(input logic [11:0] d, input int tw, input int mode);
      int fd, dummy, e0, p0, ew;
      ew = exp_width(d);
      e0 = echo_n;
      p0 = pronto_n;
      distancia = d;
      pulse(tw, fd);
      repeat (3) step();
      chk_eq("st_burst", int'(db_estado), 2);
      chk_eq("ocup_burst", int'(ocupado), 1);
      if (mode == 5) habilita = 1'b0;
      wait_echo(1'b1, BURST_DELAY + 10, "echo_up");
      chk_eq("rise_lat", rise_cyc - fd, SYNC_LAT + BURST_DELAY);
      chk_eq("st_echo", int'(db_estado), 3);
      if (mode == 1) pulse(TRIG_MIN + 2, dummy);
      if (mode == 3) distancia = 12'($urandom);
      wait_echo(1'b0, ew + 20, "echo_dn");
      chk_eq("width", last_wid, ew);
      chk_eq("pronto_at", pronto_cyc, fall_cyc);
      if (mode == 2) pulse(TRIG_MIN + 2, dummy);
      if (mode == 4) trigger = 1'b1;
      wait_idle(REARM + 10, "ocup_dn");
      chk_eq("rearm", ocup_fall_cyc - fall_cyc, REARM);
      repeat (BURST_DELAY + 20) step();
      chk_eq("one_echo", echo_n - e0, 1);
      chk_eq("one_pronto", pronto_n - p0, 1);
      chk_eq("idle", int'(db_estado), 0);
      trigger  = 1'b0;
      habilita = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [11:0] tab [6];
      logic [11:0] d;
      int fd, c0, e0, o0, p0;

      tab = '{12'h015, 12'h401, 12'h000, 12'h0A5, 12'h400, 12'h001};

      repeat (3) step();
      chk_eq("rst_echo", int'(echo), 0);
      chk_eq("rst_ocup", int'(ocupado), 0);
      chk_eq("rst_pronto", int'(pronto), 0);
      chk_eq("rst_curto", int'(trigger_curto), 0);
      chk_eq("rst_state", int'(db_estado), 0);
      reset = 1'b1;
      repeat (3) step();

      foreach (tab[i]) meas(tab[i], TRIG_MIN + 4, 0);
      meas(12'h023, TRIG_MIN, 0);

      c0 = curto_n;
      e0 = echo_n;
      pulse(TRIG_MIN - 1, fd);
      repeat (5) step();
      chk_eq("curto_n", curto_n - c0, 1);
      chk_eq("curto_at", curto_cyc - fd, SYNC_LAT + 1);
      chk_eq("curto_idle", int'(db_estado), 0);
      chk_eq("curto_noecho", echo_n - e0, 0);
      meas(12'h007, TRIG_MIN, 0);

      meas(12'h050, TRIG_MIN + 3, 1);
      meas(12'h033, TRIG_MIN + 3, 2);
      meas(12'h120, TRIG_MIN + 3, 3);
      meas(12'h042, TRIG_MIN + 3, 4);
      meas(12'h009, TRIG_MIN + 3, 0);

      habilita = 1'b0;
      o0 = ocup_rise_n;
      e0 = echo_n;
      pulse(TRIG_MIN + 5, fd);
      repeat (BURST_DELAY + 20) step();
      chk_eq("dis_ocup", ocup_rise_n - o0, 0);
      chk_eq("dis_echo", echo_n - e0, 0);
      habilita = 1'b1;
      meas(12'h061, TRIG_MIN + 2, 5);

      distancia = 12'h100;
      pulse(TRIG_MIN + 3, fd);
      wait_echo(1'b1, BURST_DELAY + 10, "rst_echo_up");
      repeat (50) step();
      p0 = pronto_n;
      @(negedge clock);
      #3;
      reset = 1'b0;
      #1;
      chk_eq("arst_echo", int'(echo), 0);
      chk_eq("arst_state", int'(db_estado), 0);
      chk_eq("arst_ocup", int'(ocupado), 0);
      repeat (3) step();
      reset = 1'b1;
      repeat (REARM + BURST_DELAY + 20) step();
      chk_eq("arst_nopronto", pronto_n - p0, 0);
      chk_eq("arst_echo_low", int'(echo), 0);
      meas(12'h018, TRIG_MIN + 1, 0);

      for (int k = 0; k < 10; k++) begin
         if ($urandom_range(0, 3) == 0) d = 12'($urandom);
         else                           d = to_bcd(int'($urandom_range(1, DIST_MAX)));
         meas(d, TRIG_MIN + int'($urandom_range(0, 15)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sensor_hcsr04_emulador.md
Name: sensor_hcsr04_emulador

Overview:
Synthesizable emulator of the HC-SR04 ultrasonic sensor, i.e. the sensor side of the trigger/echo protocol. It accepts a trigger pulse and returns an echo pulse whose width encodes a programmed 3-digit BCD distance in cm, at 2941 clocks per cm (50 MHz clock).
It replaces the physical sensor in board bring-up and closed-loop simulation of the sensor interface. It also enforces minimum trigger width, burst delay, out-of-range timeout and rearm holdoff.

Parameters:
TRIG_MIN, 500, minimum trigger high time in clocks (10 us) for a valid trigger
CM_CLOCKS, 2941, echo clocks per cm
BURST_DELAY, 25000, clocks from trigger fall to echo rise (500 us)
DIST_MAX, 400, largest distance in cm echoed normally
TIMEOUT, 1900000, echo width in clocks for out-of-range or invalid distance (38 ms)
REARM, 500000, holdoff clocks after echo fall before a new trigger is accepted (10 ms)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
trigger  in  1  trigger from the sensor interface; asynchronous, synchronized internally
distancia  in  12  programmed distance, BCD [11:8] hundreds, [7:4] tens, [3:0] units
habilita  in  1  emulator enable; when low, new triggers are ignored
echo  out  1  echo pulse to the sensor interface
ocupado  out  1  high in every state except IDLE
pronto  out  1  one-clock pulse on the cycle echo falls
trigger_curto  out  1  one-clock pulse when a trigger shorter than TRIG_MIN is rejected
db_estado  out  3  current state encoding, for debug

Behaviour:
- Reset (reset=0, async): state IDLE; echo=0, ocupado=0, pronto=0, trigger_curto=0, db_estado=IDLE; all counters cleared.
- Trigger path: 2-flop synchronizer, then edge detect on the synchronized signal (trig_s). All timing below is referenced to trig_s.
- States (encoding): IDLE=0, TRIG=1, BURST=2, ECHO=3, HOLDOFF=4.
- IDLE: on trig_s rising edge with habilita=1, go to TRIG and clear the width counter. A rising edge with habilita=0 is ignored.
- TRIG: count clocks while trig_s=1. On trig_s falling:
  - count >= TRIG_MIN: latch distancia, go to BURST.
  - otherwise: pulse trigger_curto for 1 clock, go to IDLE.
  - Trigger held high indefinitely: stay in TRIG; the width counter saturates at TRIG_MIN.
- Distance evaluation at the latch point: the distance is invalid if any BCD digit > 9, or if the value is 0 or > DIST_MAX.
  - Valid distance N = 100*d2 + 10*d1 + d0 (10-bit).
  - Changes on distancia after the latch have no effect on the current measurement.
- BURST: wait exactly BURST_DELAY clocks. echo rises on the first ECHO cycle.
- ECHO: echo=1 for exactly N*CM_CLOCKS clocks (valid distance) or TIMEOUT clocks (invalid distance).
  - Width is generated by nested counters (clocks-per-cm counter plus cm counter); no multiplier.
  - On the last echo-high clock the next state is HOLDOFF. pronto pulses on the first HOLDOFF cycle, when echo=0.
- HOLDOFF: wait REARM clocks, then go to IDLE. Any trigger activity during BURST/ECHO/HOLDOFF is ignored.
  - A trigger already high on return to IDLE does not start a measurement; a fresh rising edge is required.
- habilita falling mid-operation does not abort; the current cycle completes.
- Reset mid-echo: echo drops asynchronously to 0. pronto is not issued.
- Outputs echo, ocupado, pronto, trigger_curto and db_estado are registered; they change only on clock edges, except under async reset.
- Width rule: counters sized for TIMEOUT (21 bits) and DIST_MAX*CM_CLOCKS.

Decomposition:
- Shared package: state encoding constants; default timing constants (CM_CLOCKS=2941, TRIG_MIN=500, TIMEOUT=1900000), also consumed by the interface side for consistency.
- One sub-module, gerador_eco_cm. Inputs: start, cm count, timeout select. Outputs: the echo pulse via nested counters, plus an end pulse. It is instantiated once in the ECHO state path.
- BCD validation/conversion stays inline.

Test Plan:
- Nominal: distancia=12'h015; trigger high 600 clocks -> echo rises BURST_DELAY clocks after trig_s falls; echo high exactly 44115 clocks; pronto 1 clock after echo falls; ocupado high until HOLDOFF ends.
- Short trigger: trigger high 400 clocks -> trigger_curto pulses once; echo stays 0; state returns to IDLE; a following 500-clock trigger is accepted.
- Out of range: distancia=12'h401, 12'h000 and 12'h0A5 (invalid digit) -> echo width 1900000 clocks each.
- Boundary: distancia=12'h400 -> echo width 400*2941=1176400 clocks; distancia=12'h001 -> 2941 clocks.
- Ignore/rearm: second trigger during ECHO and HOLDOFF -> no second echo. Trigger held high across end of HOLDOFF -> no echo until trigger falls and rises again. distancia changed mid-echo -> width unchanged.
- Reset/enable: reset=0 asserted mid-ECHO -> echo=0 immediately, state IDLE, no pronto. habilita=0 with a valid trigger in IDLE -> no response. habilita dropped during BURST -> echo still produced.
